// File: rtl/sample_buffer_loader.sv
// Byte-stream packer feeding the 32-sample mean units.
// Collects one frame, launches the mean unit, then holds the frame until it is done.
module sample_buffer_loader #(
  parameter int N_SAMPLES = 32,
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic                       avg_ready,
  input  logic                       avg_done,
  output logic                       start,
  output logic [N_SAMPLES*WIDTH-1:0] samples,
  output logic [CNT_W-1:0]           count,
  output logic                       busy
);

  typedef enum logic [1:0] {
    FILL,
    WAIT_RDY,
    START,
    HOLD
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   last;

  assign accept = in_valid & in_ready;
  assign last   = (count == CNT_W'(N_SAMPLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:     if (accept && last) state_nxt = WAIT_RDY;
      WAIT_RDY: if (avg_ready)      state_nxt = START;
      START:                        state_nxt = HOLD;
      HOLD:     if (avg_done)       state_nxt = FILL;
      default:                      state_nxt = FILL;
    endcase
  end

  // in_ready is gated by rst so upstream sees a stall during reset
  always_comb begin
    in_ready = (state == FILL) & ~rst;
    start    = (state == START);
    busy     = (state != FILL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      samples <= '0;
    end else begin
      if (accept)
        count <= count + CNT_W'(1);
      else if (state == HOLD && avg_done)
        count <= '0;
      for (int i = 0; i < N_SAMPLES; i++) begin
        if (accept && count == CNT_W'(i))
          samples[i*WIDTH +: WIDTH] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_sample_buffer_loader.sv
// Randomized bench for sample_buffer_loader.
// A frame-level model predicts handshake, count, start and buffer contents.
module tb_sample_buffer_loader;
  localparam int N  = 32;
  localparam int W  = 8;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          avg_ready;
  logic          avg_done;
  logic          start;
  logic [N*W-1:0] samples;
  logic [CW-1:0] count;
  logic          busy;

  sample_buffer_loader #(.N_SAMPLES(N), .WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .avg_ready(avg_ready), .avg_done(avg_done),
    .start(start), .samples(samples), .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_start = 0;

  // Model: frame contents, fill level, and where the frame is in its life
  logic [W-1:0] mem [N];
  int m_cnt;
  bit m_wait, m_go, m_hold;

  always @(negedge clk) if (start === 1'b1) n_start++;

  function automatic logic [8:0] exp_flags();
    bit b;
    b = m_wait | m_go | m_hold;
    return {!b && !rst, b, m_go, 6'(m_cnt)};
  endfunction

  function automatic logic [N*W-1:0] exp_samples();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = mem[i];
    return v;
  endfunction

  function automatic int dut_mean();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += samples[i*W +: W];
    return s / N;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_wait = 0; m_go = 0; m_hold = 0;
    for (int i = 0; i < N; i++) mem[i] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst) begin
      if (m_hold) begin
        if (avg_done) begin m_hold = 0; m_cnt = 0; end
      end else if (m_go) begin
        m_go = 0; m_hold = 1;
      end else if (m_wait) begin
        if (avg_ready) begin m_wait = 0; m_go = 1; end
      end else if (in_valid) begin
        mem[m_cnt] = in_data;
        m_cnt++;
        if (m_cnt == N) m_wait = 1;
      end
    end
    #1;
  endtask

  task automatic feed(input logic [W-1:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; in_data = 0; avg_ready = 0; avg_done = 0;
    model_reset();
    tick(); tick();
    checks++;
    if ({in_ready, busy, start, count} !== 9'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected %b", {in_ready, busy, start, count}, 9'b0);
    end
    checks++;
    if (samples !== '0) begin
      errors++;
      $display("FAIL reset_samples: got %h expected 0", samples);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_fill_no_gaps();
    int last_acc;
    int st_cyc;
    int sc;
    avg_ready = 1; avg_done = 0;
    sc = n_start;
    st_cyc = -1;
    for (int i = 1; i <= N; i++) begin
      in_valid = 1; in_data = W'(i);
      tick();
      checks++;
      if ({in_ready, busy, start, count} !== exp_flags()) begin
        errors++;
        $display("FAIL fill_flags[%0d]: got %b expected %b", i, {in_ready, busy, start, count}, exp_flags());
      end
    end
    last_acc = cyc;
    in_valid = 0;
    repeat (4) begin
      tick();
      if (start === 1'b1 && st_cyc < 0) st_cyc = cyc;
    end
    checks++;
    if (st_cyc !== last_acc + 1) begin
      errors++;
      $display("FAIL fill_start_latency: got edge %0d expected %0d", st_cyc, last_acc + 1);
    end
    checks++;
    if (n_start - sc !== 1) begin
      errors++;
      $display("FAIL fill_start_pulses: got %0d expected 1", n_start - sc);
    end
    checks++;
    if (samples[7:0] !== 8'd1 || samples[255:248] !== 8'd32) begin
      errors++;
      $display("FAIL fill_ends: got %h/%h expected 01/20", samples[7:0], samples[255:248]);
    end
    checks++;
    if (dut_mean() !== 16 || count !== 6'd32) begin
      errors++;
      $display("FAIL fill_mean: got mean %0d count %0d expected 16 32", dut_mean(), count);
    end
    avg_done = 1; tick(); avg_done = 0;
    checks++;
    if (in_ready !== 1'b1 || count !== 6'd0) begin
      errors++;
      $display("FAIL fill_release: got ready %b count %0d expected 1 0", in_ready, count);
    end
  endtask

  task automatic test_gapped();
    int acc;
    int ph;
    int sc;
    acc = 0; ph = 0;
    sc = n_start;
    avg_ready = 1;
    while (acc < N && ph < 400) begin
      in_valid = (ph % 4 == 0) || (ph % 4 == 3);
      in_data = 8'hFF;
      tick();
      if (in_valid) acc++;
      ph++;
      checks++;
      if (count !== 6'(acc)) begin
        errors++;
        $display("FAIL gap_count[%0d]: got %0d expected %0d", ph, count, acc);
      end
    end
    in_valid = 0;
    repeat (3) tick();
    checks++;
    if (n_start - sc !== 1 || dut_mean() !== 255) begin
      errors++;
      $display("FAIL gap_result: got starts %0d mean %0d expected 1 255", n_start - sc, dut_mean());
    end
    avg_done = 1; tick(); avg_done = 0;
  endtask

  task automatic test_ready_stall();
    avg_ready = 0;
    for (int i = 0; i < N; i++) feed(W'($urandom));
    repeat (10) begin
      tick();
      checks++;
      if (start !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_wait: got start %b ready %b busy %b expected 0 0 1", start, in_ready, busy);
      end
    end
    avg_ready = 1;
    tick();
    checks++;
    if (start !== 1'b1) begin
      errors++;
      $display("FAIL stall_start: got %b expected 1", start);
    end
    tick();
    checks++;
    if (samples !== exp_samples()) begin
      errors++;
      $display("FAIL stall_samples: got %h expected %h", samples, exp_samples());
    end
  endtask

  task automatic test_hold_protection();
    logic [N*W-1:0] snap;
    snap = exp_samples();
    avg_ready = 0;
    in_valid = 1; in_data = 8'hAA;
    repeat (20) begin
      tick();
      checks++;
      if (samples !== snap || count !== 6'd32 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_frozen: got count %0d ready %b expected 32 0", count, in_ready);
      end
    end
    in_valid = 0;
    avg_done = 1; tick(); avg_done = 0;
    checks++;
    if (in_ready !== 1'b1 || count !== 6'd0) begin
      errors++;
      $display("FAIL hold_release: got ready %b count %0d expected 1 0", in_ready, count);
    end
    feed(8'h5A);
    checks++;
    if (samples[7:0] !== 8'h5A || samples[15:8] !== snap[15:8] || count !== 6'd1) begin
      errors++;
      $display("FAIL hold_next_frame: got %h %h cnt %0d expected 5a %h 1", samples[7:0], samples[15:8], count, snap[15:8]);
    end
  endtask

  task automatic test_reset_mid_fill();
    int sc;
    avg_ready = 1;
    while (m_cnt < 10) feed(W'($urandom));
    checks++;
    if (count !== 6'd10) begin
      errors++;
      $display("FAIL midrst_pre: got %0d expected 10", count);
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (count !== 6'd0 || samples !== '0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: got count %0d ready %b busy %b expected 0 0 0", count, in_ready, busy);
    end
    tick();
    rst = 1'b0;
    sc = n_start;
    for (int i = 0; i < N; i++) feed(8'd4);
    repeat (4) tick();
    checks++;
    if (n_start - sc !== 1 || dut_mean() !== 4) begin
      errors++;
      $display("FAIL midrst_frame: got starts %0d mean %0d expected 1 4", n_start - sc, dut_mean());
    end
  endtask

  task automatic test_back_to_back();
    int sc;
    sc = n_start;
    avg_done = 1;
    in_valid = 1; in_data = 8'd32;
    tick();
    checks++;
    if (count !== 6'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_release: got count %0d ready %b expected 0 1", count, in_ready);
    end
    for (int v = 32; v >= 1; v--) begin
      in_valid = 1; in_data = W'(v);
      if (v < 29) avg_done = 0;
      tick();
      checks++;
      if (count !== 6'(33 - v)) begin
        errors++;
        $display("FAIL b2b_count[%0d]: got %0d expected %0d", v, count, 33 - v);
      end
    end
    in_valid = 0;
    repeat (4) tick();
    checks++;
    if (n_start - sc !== 1 || samples[7:0] !== 8'd32 || samples[255:248] !== 8'd1) begin
      errors++;
      $display("FAIL b2b_frame: got starts %0d first %0d last %0d expected 1 32 1", n_start - sc, samples[7:0], samples[255:248]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      avg_ready = $urandom_range(0, 1) == 1;
      avg_done  = ($urandom_range(0, 9) < 3);
      tick();
      checks++;
      if ({in_ready, busy, start, count} !== exp_flags()) begin
        errors++;
        $display("FAIL rand_flags[%0d]: got %b expected %b", c, {in_ready, busy, start, count}, exp_flags());
      end
      checks++;
      if (samples !== exp_samples()) begin
        errors++;
        $display("FAIL rand_samples[%0d]: got %h expected %h", c, samples, exp_samples());
      end
    end
    in_valid = 0; avg_done = 0; avg_ready = 0;
  endtask

  initial begin
    test_reset();
    test_fill_no_gaps();
    test_gapped();
    test_ready_stall();
    test_hold_protection();
    test_reset_mid_fill();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
